time_display_scan: RTL and testbench
====================================

Name: time_display_scan

Overview:
- Reader/consumer end of the packed 20-bit BCD time bus from the clock counter.
- Unpacks the bus and drives a 6-digit multiplexed 7-segment display as HH.MM.SS.
- Latches a coherent snapshot once per scan frame.
- Blinks the separator dots once per second, optionally blanks the leading hour zero, and flags malformed time values.

Parameters:
- SCAN_DIV, 50000: clk_sys cycles each digit stays selected (minimum 2).
- HALF_SEC, 25000000: clk_sys cycles the separator dots stay lit after each seconds change.
- SEG_ACTIVE_LOW, 1: 1 means seg and dp are driven low-true; 0 means high-true.
- AN_ACTIVE_LOW, 1: 1 means an is driven low-true; 0 means high-true.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous reset, active-high
- time_in  in  20  packed BCD {hou_h[19:18], hou_l[17:14], min_h[13:11], min_l[10:7], sec_h[6:4], sec_l[3:0]}
- blank_lz  in  1  1 blanks digit 5 when hou_h==0
- an  out  6  digit enables; an[0]=sec_l ... an[5]=hou_h
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point of the currently selected digit
- err  out  1  snapshot holds an invalid time

Behaviour:
- Reset is synchronous, active-high, and applies on any cycle, including mid-frame:
  - scan_cnt=0, idx=0, snap=0, prev_sec=0, colon_on=0, blink_cnt=0, err=0.
  - an=all digits off, seg=all segments off, dp=off (in the configured polarity).
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - When scan_cnt==SCAN_DIV-1, idx advances 0→1→…→5→0.
- Snapshot:
  - On the cycle with idx==5 and scan_cnt==SCAN_DIV-1, snap<=time_in and err<=invalid(time_in).
  - time_in changes at any other time have no effect until the next frame boundary.
- invalid(t) is true if any of the following holds:
  - sec_l>9, min_l>9, or hou_l>9;
  - sec_h>5 or min_h>5;
  - hou_h>2;
  - hou_h==2 and hou_l>3.
- Field select: the field for digit idx is taken from snap and zero-extended to 4 bits.
- Segment decode (high-true gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Values 10..15 decode to a dash (40).
  - When SEG_ACTIVE_LOW=1 the pattern is inverted.
- Output timing:
  - an, seg and dp are registered and reflect idx/snap of the previous cycle (1-cycle latency).
  - Each digit is therefore held SCAN_DIV cycles, offset by one cycle from idx.
- Leading-zero blank: when blank_lz=1, idx==5 and snap hou_h==0, all anodes are off during that slot; seg is don't-care in that slot.
- Separator blink:
  - prev_sec<=time_in[3:0] every cycle.
  - When time_in[3:0]!=prev_sec: colon_on<=1 and blink_cnt<=0.
  - Otherwise, while colon_on=1, blink_cnt increments; on reaching HALF_SEC-1, colon_on<=0.
  - If the seconds digit never changes, the dots stay dark.
- dp is asserted only when colon_on=1 and the selected digit is 2 or 4.
- No other state exists; anodes are never asserted for more than one digit at a time.

Test Plan:
- Run with SCAN_DIV=4 and HALF_SEC=8.
- Reset: hold rst=1 for 3 cycles with any time_in, then release.
  - During reset: an=6'b111111, seg=7'h7F, dp=1, err=0.
  - First cycle after release: an=6'b111110, seg=7'h40 ('0').
- Full frame of 23:59:58 (time_in=20'h8ECD8) loaded before a boundary:
  - Next frame shows an 111110/111101/111011/110111/101111/011111, each held 4 cycles.
  - seg per digit: 00, 12, 10, 12, 30, 24.
  - err=0.
- Coherence: change time_in to 20'h00000 while idx=2.
  - Digits 3..5 of the current frame still show 5, 3, 2.
  - Zeros appear only from the next frame.
- Blanking: time_in=09:05:00 (20'h24280).
  - blank_lz=1: an[5] never asserted; digit 4 shows '9' (10).
  - blank_lz=0: digit 5 shows '0' (40).
- Invalid input: time_in with min_l=4'hC.
  - After the frame boundary: err=1 and digit 2 shows a dash (3F).
  - Restore valid time: err=0 after the next boundary.
  - Separately, 24:00:00 (hou_h=2, hou_l=4) sets err=1 with digits shown normally.
- Blink: toggle sec_l from 0 to 1.
  - Starting the cycle after the change, dp=0 whenever digit 2 or 4 is selected.
  - After 8 cycles dp stays 1 until the next sec_l change.
  - Verify with a mid-blink change that the 8-cycle window restarts.

Source files
------------

// File: rtl/time_display_scan.sv
// Multiplexed HH.MM.SS display driver for the packed BCD time bus.
// It latches one coherent snapshot per scan frame and blinks the separator dots on each seconds change.
module time_display_scan #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned HALF_SEC       = 25000000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [19:0] time_in,
    input  logic        blank_lz,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        err
);

    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned BW = (HALF_SEC > 1) ? $clog2(HALF_SEC) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF_SEC - 1);
    localparam logic [5:0] AN_OFF  = AN_ACTIVE_LOW  ? '1 : '0;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [19:0]   snap;
    logic [3:0]    prev_sec;
    logic          colon_on;
    logic [BW-1:0] blink_cnt;

    logic [3:0] digit;
    logic       blank;
    logic [5:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    function automatic logic invalid(input logic [19:0] t);
        return (t[3:0] > 4'd9) || (t[10:7] > 4'd9) || (t[17:14] > 4'd9) ||
               (t[6:4] > 3'd5) || (t[13:11] > 3'd5) || (t[19:18] > 2'd2) ||
               ((t[19:18] == 2'd2) && (t[17:14] > 4'd3));
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    always_comb begin
        digit = '0;
        case (idx)
            3'd0:    digit = snap[3:0];
            3'd1:    digit = {1'b0, snap[6:4]};
            3'd2:    digit = snap[10:7];
            3'd3:    digit = {1'b0, snap[13:11]};
            3'd4:    digit = snap[17:14];
            3'd5:    digit = {2'b00, snap[19:18]};
            default: digit = '0;
        endcase
        seg_next = decode(digit) ^ SEG_OFF;
        blank    = blank_lz && (idx == 3'd5) && (snap[19:18] == 2'd0);
        an_next  = AN_OFF;
        if (!blank && (idx <= 3'd5))
            an_next = (6'd1 << idx) ^ AN_OFF;
        dp_next  = (colon_on && ((idx == 3'd2) || (idx == 3'd4))) ^ DP_OFF;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= '0;
            snap      <= '0;
            prev_sec  <= '0;
            colon_on  <= 1'b0;
            blink_cnt <= '0;
            err       <= 1'b0;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                // Frame boundary: the only point where a new time is taken in.
                if (idx == 3'd5) begin
                    snap <= time_in;
                    err  <= invalid(time_in);
                end
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            prev_sec <= time_in[3:0];
            if (time_in[3:0] != prev_sec) begin
                colon_on  <= 1'b1;
                blink_cnt <= '0;
            end else if (colon_on) begin
                if (blink_cnt == BLINK_LAST)
                    colon_on <= 1'b0;
                else
                    blink_cnt <= blink_cnt + 1'b1;
            end

            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with SCAN_DIV=4 and HALF_SEC=8.
// Edge count cyc restarts at 1 on the first edge after reset is released, so the digit shown is ((cyc-1)/4)%6.
module tb_time_display_scan;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] time_in = 20'h8ECD8;
    logic        blank_lz = 1'b0;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    time_display_scan #(
        .SCAN_DIV(4),
        .HALF_SEC(8),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_sys(clk_sys),
        .rst(rst),
        .time_in(time_in),
        .blank_lz(blank_lz),
        .an(an),
        .seg(seg),
        .dp(dp),
        .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    // Passes at least one edge, ending just after a frame boundary edge.
    task automatic wait_boundary();
        step();
        while (cyc % 24 != 0) step();
    endtask

    function automatic int digit_now();
        return ((cyc - 1) / 4) % 6;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold an=%b seg=%h dp=%b err=%b want an=111111 seg=7f dp=1 err=0",
                         an, seg, dp, err);
            end
        end
        rst = 1'b0;
        cyc = 0;
        step();
        checks++;
        if (an !== 6'b111110 || seg !== 7'h40 || dp !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_first an=%b seg=%h dp=%b err=%b want an=111110 seg=40 dp=1 err=0",
                     an, seg, dp, err);
        end
    endtask

    task automatic test_full_frame();
        logic [6:0] exp_seg [6];
        int d;
        exp_seg = '{7'h00, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
        time_in = 20'h8ECD8;
        wait_boundary();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err got %b want 0", err);
        end
        for (int i = 0; i < 24; i++) begin
            step();
            d = digit_now();
            checks++;
            if (an !== (6'h3F ^ (6'd1 << d)) || seg !== exp_seg[d]) begin
                errors++;
                $display("FAIL frame_digit cyc=%0d d=%0d an=%b seg=%h want an=%b seg=%h",
                         cyc, d, an, seg, 6'h3F ^ (6'd1 << d), exp_seg[d]);
            end
        end
    endtask

    task automatic test_coherence();
        logic [6:0] old_seg [6];
        int d;
        old_seg = '{7'h00, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
        time_in = 20'h8ECD8;
        wait_boundary();
        for (int i = 0; i < 9; i++) step();
        time_in = 20'h00000;
        while (cyc % 24 != 0) begin
            step();
            d = digit_now();
            checks++;
            if (an !== (6'h3F ^ (6'd1 << d)) || seg !== old_seg[d]) begin
                errors++;
                $display("FAIL coherence_old cyc=%0d d=%0d an=%b seg=%h want an=%b seg=%h",
                         cyc, d, an, seg, 6'h3F ^ (6'd1 << d), old_seg[d]);
            end
        end
        for (int i = 0; i < 24; i++) begin
            step();
            d = digit_now();
            checks++;
            if (an !== (6'h3F ^ (6'd1 << d)) || seg !== 7'h40) begin
                errors++;
                $display("FAIL coherence_new cyc=%0d d=%0d an=%b seg=%h want an=%b seg=40",
                         cyc, d, an, seg, 6'h3F ^ (6'd1 << d));
            end
        end
    endtask

    task automatic test_blanking();
        int d;
        time_in  = 20'h24280;
        blank_lz = 1'b1;
        wait_boundary();
        for (int i = 0; i < 24; i++) begin
            step();
            d = digit_now();
            checks++;
            if (d == 5) begin
                if (an !== 6'h3F) begin
                    errors++;
                    $display("FAIL blank_on cyc=%0d an=%b want 111111", cyc, an);
                end
            end else if (an !== (6'h3F ^ (6'd1 << d)) || (d == 4 && seg !== 7'h10)) begin
                errors++;
                $display("FAIL blank_other cyc=%0d d=%0d an=%b seg=%h want an=%b (seg=10 on d4)",
                         cyc, d, an, seg, 6'h3F ^ (6'd1 << d));
            end
        end
        blank_lz = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (digit_now() == 5) begin
                checks++;
                if (an !== 6'b011111 || seg !== 7'h40) begin
                    errors++;
                    $display("FAIL blank_off cyc=%0d an=%b seg=%h want an=011111 seg=40", cyc, an, seg);
                end
            end
        end
    endtask

    task automatic test_invalid();
        logic [6:0] exp_seg [6];
        int d;
        exp_seg = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24};
        time_in = 20'h8EE58;
        step();
        while (cyc % 24 != 23) step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_early got err=%b want 0", err);
        end
        step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_min_l got err=%b want 1", err);
        end
        for (int i = 0; i < 24; i++) begin
            step();
            if (digit_now() == 2) begin
                checks++;
                if (an !== 6'b111011 || seg !== 7'h3F) begin
                    errors++;
                    $display("FAIL invalid_dash cyc=%0d an=%b seg=%h want an=111011 seg=3f", cyc, an, seg);
                end
            end
        end
        time_in = 20'h8ECD8;
        wait_boundary();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_restore got err=%b want 0", err);
        end
        time_in = 20'h90000;
        wait_boundary();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_24h got err=%b want 1", err);
        end
        for (int i = 0; i < 24; i++) begin
            step();
            d = digit_now();
            checks++;
            if (an !== (6'h3F ^ (6'd1 << d)) || seg !== exp_seg[d]) begin
                errors++;
                $display("FAIL invalid_24h_digit cyc=%0d d=%0d an=%b seg=%h want an=%b seg=%h",
                         cyc, d, an, seg, 6'h3F ^ (6'd1 << d), exp_seg[d]);
            end
        end
    endtask

    task automatic test_blink();
        int chg_a;
        int chg_b;
        int d;
        logic win;
        logic exp_dp;
        time_in = 20'h90000;
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if (dp !== 1'b1) begin
                errors++;
                $display("FAIL blink_dark cyc=%0d dp=%b want 1", cyc, dp);
            end
        end
        // Single change: dots lit for the 8 edges starting two edges after the change.
        while (cyc % 24 != 8) step();
        time_in = 20'h90001;
        chg_a = cyc;
        chg_b = -100;
        for (int i = 0; i < 48; i++) begin
            step();
            d = digit_now();
            win = (cyc >= chg_a + 2 && cyc <= chg_a + 9);
            exp_dp = (win && (d == 2 || d == 4)) ? 1'b0 : 1'b1;
            checks++;
            if (dp !== exp_dp) begin
                errors++;
                $display("FAIL blink_single cyc=%0d d=%0d dp=%b want %b", cyc, d, dp, exp_dp);
            end
        end
        // A second change mid-window restarts the 8-cycle count.
        while (cyc % 24 != 8) step();
        time_in = 20'h90000;
        chg_a = cyc;
        for (int i = 0; i < 4; i++) step();
        time_in = 20'h90002;
        chg_b = cyc;
        for (int i = 0; i < 40; i++) begin
            step();
            d = digit_now();
            win = (cyc >= chg_a + 2 && cyc <= chg_a + 9) || (cyc >= chg_b + 2 && cyc <= chg_b + 9);
            exp_dp = (win && (d == 2 || d == 4)) ? 1'b0 : 1'b1;
            checks++;
            if (dp !== exp_dp) begin
                errors++;
                $display("FAIL blink_restart cyc=%0d d=%0d dp=%b want %b", cyc, d, dp, exp_dp);
            end
        end
    endtask

    task automatic test_reset_midframe();
        time_in = 20'h8EE58;
        wait_boundary();
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre got err=%b want 1", err);
        end
        test_reset();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_coherence();
        test_blanking();
        test_invalid();
        test_blink();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
